ahb_slave_burst_if: RTL and testbench

//  Parametrised AHB-Lite slave front end that converts AHB transfers into single-beat requests on the "other" backend port.

---
 rtl/ahb_slave_burst_if.sv | 198 +++++++++++++++++++
 tb/tb_ahb_slave_burst_if.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_burst_if.sv
// AHB-Lite slave front end: turns AHB single/INCR/WRAP transfers into single-beat
// backend requests, with backend wait states, ready timeout and the two-cycle ERROR response.
module ahb_slave_burst_if #(
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 16
) (
  input  logic                          ahb_clk_in,
  input  logic                          ahb_rstn_in,
  input  logic                          ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]     ahb_addr_in,
  input  logic [1:0]                    ahb_trans_in,
  input  logic                          ahb_write_in,
  input  logic [2:0]                    ahb_size_in,
  input  logic [2:0]                    ahb_burst_in,
  input  logic [AHB_DATA_WIDTH-1:0]     ahb_wdata_in,
  input  logic                          ahb_ready_in,
  output logic                          ahb_ready_out,
  output logic                          ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]     ahb_rdata_out,
  output logic                          other_req_out,
  output logic [AHB_ADDR_WIDTH-1:0]     other_addr_out,
  output logic                          other_write_out,
  output logic [2:0]                    other_size_out,
  output logic [AHB_DATA_WIDTH/8-1:0]   other_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]     other_wdata_out,
  input  logic [AHB_DATA_WIDTH-1:0]     other_rdata_in,
  input  logic                          other_ready_in,
  input  logic                          other_error_in
);

  localparam int AW       = AHB_ADDR_WIDTH;
  localparam int SW       = AHB_DATA_WIDTH / 8;
  localparam int LB       = $clog2(SW);
  localparam int CW       = (AHB_WAIT_TIMEOUT > 1) ? $clog2(AHB_WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((AHB_WAIT_TIMEOUT > 0) ? AHB_WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_e;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_e;

  state_e          state;
  logic [CW-1:0]   wait_cnt;

  // Burst context captured at NONSEQ; beats_left counts remaining SEQ beats.
  logic            burst_open;
  logic            burst_unb;
  logic [4:0]      beats_left;
  logic [AW-1:0]   exp_addr;
  logic [AW-1:0]   wrap_mask;
  logic [2:0]      burst_size;
  logic [2:0]      burst_type;
  logic            burst_write;

  logic            sample_en, addr_valid, is_seq;
  logic            size_bad, misaligned, seq_bad, kb_cross, chk_err;
  logic            accept, reject, busy_hold, timeout_hit;
  logic [AW-1:0]   beat_incr, align_mask, nonseq_mask, cur_mask, next_addr;
  logic [4:0]      nonseq_beats;
  logic [LB-1:0]   byte_off;
  logic [SW-1:0]   strb_calc;

  always_comb begin
    sample_en   = ahb_ready_out && (state != S_ERR1);
    addr_valid  = ahb_sel_in && ahb_ready_in && ahb_trans_in[1];
    is_seq      = (ahb_trans_in == TR_SEQ);
    busy_hold   = ahb_sel_in && (ahb_trans_in == TR_BUSY);
    beat_incr   = AW'(1) << ahb_size_in;
    align_mask  = beat_incr - AW'(1);
    size_bad    = int'(ahb_size_in) > LB;
    misaligned  = (ahb_addr_in & align_mask) != '0;
    seq_bad     = !burst_open || (ahb_addr_in != exp_addr) || (ahb_size_in != burst_size) ||
                  (ahb_write_in != burst_write) || (ahb_burst_in != burst_type);
    // Aligned beats never straddle 1KB themselves; a SEQ landing on a 1KB edge crossed it.
    kb_cross    = ahb_burst_in[0] && (ahb_addr_in[9:0] == 10'd0);
    chk_err     = size_bad || misaligned || (is_seq && (seq_bad || kb_cross));
    accept      = sample_en && addr_valid && !chk_err;
    reject      = sample_en && addr_valid && chk_err;
    timeout_hit = (AHB_WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    nonseq_mask  = '1;
    nonseq_beats = 5'd0;
    case (ahb_burst_in)
      3'd2: begin nonseq_mask = (AW'(4)  << ahb_size_in) - AW'(1); nonseq_beats = 5'd3;  end
      3'd3: nonseq_beats = 5'd3;
      3'd4: begin nonseq_mask = (AW'(8)  << ahb_size_in) - AW'(1); nonseq_beats = 5'd7;  end
      3'd5: nonseq_beats = 5'd7;
      3'd6: begin nonseq_mask = (AW'(16) << ahb_size_in) - AW'(1); nonseq_beats = 5'd15; end
      3'd7: nonseq_beats = 5'd15;
      default: ;
    endcase

    // An all-ones mask makes the wrap formula degenerate to a plain increment.
    cur_mask  = is_seq ? wrap_mask : nonseq_mask;
    next_addr = (ahb_addr_in & ~cur_mask) | ((ahb_addr_in + beat_incr) & cur_mask);

    byte_off  = ahb_addr_in[LB-1:0];
    strb_calc = '0;
    for (int i = 0; i < SW; i++)
      strb_calc[i] = (i >= int'(byte_off)) && (i < int'(byte_off) + (1 << ahb_size_in));
  end

  assign other_wdata_out = other_req_out ? ahb_wdata_in : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state           <= S_IDLE;
      ahb_ready_out   <= 1'b1;
      ahb_resp_out    <= 1'b0;
      ahb_rdata_out   <= '0;
      other_req_out   <= 1'b0;
      other_addr_out  <= '0;
      other_write_out <= 1'b0;
      other_size_out  <= '0;
      other_strb_out  <= '0;
      wait_cnt        <= '0;
      burst_open      <= 1'b0;
      burst_unb       <= 1'b0;
      beats_left      <= '0;
      exp_addr        <= '0;
      wrap_mask       <= '0;
      burst_size      <= '0;
      burst_type      <= '0;
      burst_write     <= 1'b0;
    end else begin
      if (sample_en && ahb_ready_in) begin
        if (accept) begin
          exp_addr <= next_addr;
          if (is_seq) begin
            if (!burst_unb) begin
              beats_left <= beats_left - 5'd1;
              if (beats_left == 5'd1) burst_open <= 1'b0;
            end
          end else begin
            burst_unb   <= (ahb_burst_in == 3'd1);
            burst_open  <= (ahb_burst_in == 3'd1) || (nonseq_beats != 5'd0);
            beats_left  <= nonseq_beats;
            wrap_mask   <= nonseq_mask;
            burst_size  <= ahb_size_in;
            burst_type  <= ahb_burst_in;
            burst_write <= ahb_write_in;
          end
        end else if (!busy_hold) begin
          burst_open <= 1'b0;
        end
      end

      case (state)
        S_IDLE, S_ERR2: begin
          if (accept) begin
            state           <= S_ACCESS;
            other_req_out   <= 1'b1;
            other_addr_out  <= ahb_addr_in;
            other_write_out <= ahb_write_in;
            other_size_out  <= ahb_size_in;
            other_strb_out  <= strb_calc;
            wait_cnt        <= '0;
            ahb_ready_out   <= 1'b0;
            ahb_resp_out    <= 1'b0;
          end else if (reject) begin
            state         <= S_ERR1;
            ahb_ready_out <= 1'b0;
            ahb_resp_out  <= 1'b1;
          end else begin
            state         <= S_IDLE;
            ahb_ready_out <= 1'b1;
            ahb_resp_out  <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (other_error_in || (!other_ready_in && timeout_hit)) begin
            state         <= S_ERR1;
            other_req_out <= 1'b0;
            ahb_ready_out <= 1'b0;
            ahb_resp_out  <= 1'b1;
            burst_open    <= 1'b0;
          end else if (other_ready_in) begin
            state         <= S_IDLE;
            other_req_out <= 1'b0;
            ahb_ready_out <= 1'b1;
            ahb_resp_out  <= 1'b0;
            if (!other_write_out) ahb_rdata_out <= other_rdata_in;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_ERR1: begin
          state         <= S_ERR2;
          ahb_ready_out <= 1'b1;
          ahb_resp_out  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_burst_if.sv
// Directed bench for ahb_slave_burst_if: table of AHB beats with hand-computed
// backend expectations, plus hand sequences for error, timeout and reset corners.
module tb_ahb_slave_burst_if;

  logic        ahb_clk_in = 1'b0;
  logic        ahb_rstn_in;
  logic        ahb_sel_in;
  logic [31:0] ahb_addr_in;
  logic [1:0]  ahb_trans_in;
  logic        ahb_write_in;
  logic [2:0]  ahb_size_in;
  logic [2:0]  ahb_burst_in;
  logic [31:0] ahb_wdata_in;
  logic        ahb_ready_in;
  logic        ahb_ready_out;
  logic        ahb_resp_out;
  logic [31:0] ahb_rdata_out;
  logic        other_req_out;
  logic [31:0] other_addr_out;
  logic        other_write_out;
  logic [2:0]  other_size_out;
  logic [3:0]  other_strb_out;
  logic [31:0] other_wdata_out;
  logic [31:0] other_rdata_in;
  logic        other_ready_in;
  logic        other_error_in;

  always #5 ahb_clk_in = ~ahb_clk_in;

  // Single-slave system: the interconnect HREADY is this slave's HREADYOUT.
  assign ahb_ready_in = ahb_ready_out;

  ahb_slave_burst_if #(
    .AHB_DATA_WIDTH(32),
    .AHB_ADDR_WIDTH(32),
    .AHB_WAIT_TIMEOUT(4)
  ) u_dut (
    .ahb_clk_in(ahb_clk_in),
    .ahb_rstn_in(ahb_rstn_in),
    .ahb_sel_in(ahb_sel_in),
    .ahb_addr_in(ahb_addr_in),
    .ahb_trans_in(ahb_trans_in),
    .ahb_write_in(ahb_write_in),
    .ahb_size_in(ahb_size_in),
    .ahb_burst_in(ahb_burst_in),
    .ahb_wdata_in(ahb_wdata_in),
    .ahb_ready_in(ahb_ready_in),
    .ahb_ready_out(ahb_ready_out),
    .ahb_resp_out(ahb_resp_out),
    .ahb_rdata_out(ahb_rdata_out),
    .other_req_out(other_req_out),
    .other_addr_out(other_addr_out),
    .other_write_out(other_write_out),
    .other_size_out(other_size_out),
    .other_strb_out(other_strb_out),
    .other_wdata_out(other_wdata_out),
    .other_rdata_in(other_rdata_in),
    .other_ready_in(other_ready_in),
    .other_error_in(other_error_in)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    int          wait_cyc;
    logic [31:0] data;
    logic        exp_err;
    logic [3:0]  exp_strb;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = '0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ahb_clk_in);
    #1;
  endtask

  function automatic vec_t mk(logic sel, logic [1:0] tr, logic [31:0] a, logic w,
                              logic [2:0] sz, logic [2:0] b, int wt, logic [31:0] d,
                              logic err, logic [3:0] strb);
    vec_t v;
    v.sel = sel; v.trans = tr; v.addr = a; v.write = w; v.size = sz; v.burst = b;
    v.wait_cyc = wt; v.data = d; v.exp_err = err; v.exp_strb = strb;
    return v;
  endfunction

  task automatic drive_addr(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                            input logic w, input logic [2:0] sz, input logic [2:0] b);
    ahb_sel_in = sel; ahb_trans_in = tr; ahb_addr_in = a;
    ahb_write_in = w; ahb_size_in = sz; ahb_burst_in = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ahb_rstn_in = 1'b0;
    drive_addr(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    ahb_wdata_in = '0; other_rdata_in = '0; other_ready_in = 1'b0; other_error_in = 1'b0;

    //      sel  trans  addr         wr   size  burst wait data           err  strb
    vecs.push_back(mk(1, 2'd2, 32'h100, 0, 3'd2, 3'd0, 2, 32'hCAFE_0100, 0, 4'hF));
    vecs.push_back(mk(1, 2'd2, 32'h013, 1, 3'd0, 3'd0, 0, 32'hAB00_0000, 0, 4'h8));
    vecs.push_back(mk(1, 2'd2, 32'h038, 0, 3'd2, 3'd2, 0, 32'h1111_0038, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h03C, 0, 3'd2, 3'd2, 1, 32'h2222_003C, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h030, 0, 3'd2, 3'd2, 0, 32'h3333_0030, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h034, 0, 3'd2, 3'd2, 0, 32'h4444_0034, 0, 4'hF));
    vecs.push_back(mk(1, 2'd0, 32'h000, 0, 3'd0, 3'd0, 0, 32'h0,         0, 4'h0));
    vecs.push_back(mk(1, 2'd2, 32'h101, 0, 3'd1, 3'd0, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(1, 2'd2, 32'h040, 1, 3'd2, 3'd3, 1, 32'h5555_0040, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h048, 1, 3'd2, 3'd3, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(1, 2'd3, 32'h04C, 1, 3'd2, 3'd3, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(1, 2'd2, 32'h200, 0, 3'd3, 3'd0, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(1, 2'd2, 32'h3F8, 0, 3'd2, 3'd1, 0, 32'h6666_03F8, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h3FC, 0, 3'd2, 3'd1, 0, 32'h7777_03FC, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h400, 0, 3'd2, 3'd1, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(1, 2'd2, 32'h102, 1, 3'd1, 3'd0, 0, 32'h1234_0000, 0, 4'hC));
    vecs.push_back(mk(1, 2'd2, 32'h080, 0, 3'd2, 3'd3, 0, 32'h8888_0080, 0, 4'hF));
    vecs.push_back(mk(1, 2'd1, 32'h084, 0, 3'd2, 3'd3, 0, 32'h0,         0, 4'h0));
    vecs.push_back(mk(1, 2'd3, 32'h084, 0, 3'd2, 3'd3, 0, 32'h9999_0084, 0, 4'hF));
    vecs.push_back(mk(1, 2'd2, 32'h090, 0, 3'd2, 3'd0, 0, 32'hAAAA_0090, 0, 4'hF));
    vecs.push_back(mk(1, 2'd3, 32'h094, 0, 3'd2, 3'd0, 0, 32'h0,         1, 4'h0));
    vecs.push_back(mk(0, 2'd2, 32'h0A0, 0, 3'd2, 3'd0, 0, 32'h0,         0, 4'h0));
    vecs.push_back(mk(1, 2'd0, 32'h000, 0, 3'd0, 3'd0, 0, 32'h0,         0, 4'h0));

    repeat (2) @(posedge ahb_clk_in);
    #1;
    check("rst ready_out", ahb_ready_out, 1);
    check("rst resp", ahb_resp_out, 0);
    check("rst rdata", ahb_rdata_out, 0);
    check("rst req", other_req_out, 0);
    check("rst addr", other_addr_out, 0);
    check("rst strb", other_strb_out, 0);
    check("rst size/write", {other_size_out, other_write_out}, 0);
    ahb_rstn_in = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v = vecs[i];
      check($sformatf("v%0d ready_at_addr", i), ahb_ready_out, 1);
      drive_addr(v.sel, v.trans, v.addr, v.write, v.size, v.burst);
      tick();
      if (!(v.sel && v.trans[1])) begin
        check($sformatf("v%0d noreq req", i), other_req_out, 0);
        check($sformatf("v%0d noreq ready/resp", i), {ahb_ready_out, ahb_resp_out}, 2'b10);
      end else if (v.exp_err) begin
        check($sformatf("v%0d err1 req", i), other_req_out, 0);
        check($sformatf("v%0d err1 ready/resp", i), {ahb_ready_out, ahb_resp_out}, 2'b01);
        tick();
        check($sformatf("v%0d err2 ready/resp", i), {ahb_ready_out, ahb_resp_out}, 2'b11);
      end else begin
        ahb_wdata_in = v.write ? v.data : 32'h0;
        #1;
        check($sformatf("v%0d req", i), other_req_out, 1);
        check($sformatf("v%0d addr", i), other_addr_out, v.addr);
        check($sformatf("v%0d strb", i), other_strb_out, v.exp_strb);
        check($sformatf("v%0d size", i), other_size_out, v.size);
        check($sformatf("v%0d write", i), other_write_out, v.write);
        if (v.write) check($sformatf("v%0d wdata", i), other_wdata_out, v.data);
        for (int k = 0; k < v.wait_cyc; k++) begin
          check($sformatf("v%0d stall%0d ready", i, k), ahb_ready_out, 0);
          tick();
        end
        other_ready_in = 1'b1;
        other_rdata_in = v.write ? 32'hDEAD_BEEF : v.data;
        check($sformatf("v%0d last_wait ready", i), ahb_ready_out, 0);
        tick();
        other_ready_in = 1'b0;
        check($sformatf("v%0d done ready/resp", i), {ahb_ready_out, ahb_resp_out}, 2'b10);
        check($sformatf("v%0d done req", i), other_req_out, 0);
        if (!v.write) begin
          last_rd = v.data;
          check($sformatf("v%0d rdata", i), ahb_rdata_out, v.data);
        end
      end
    end

    // Backend error wins over ready; read data must not be updated.
    drive_addr(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 3'd0);
    tick();
    drive_addr(1'b1, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    check("berr req", other_req_out, 1);
    other_ready_in = 1'b1; other_error_in = 1'b1; other_rdata_in = 32'h5A5A_5A5A;
    tick();
    other_ready_in = 1'b0; other_error_in = 1'b0;
    check("berr err1 ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b01);
    check("berr err1 req", other_req_out, 0);
    tick();
    check("berr err2 ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b11);
    check("berr rdata held", ahb_rdata_out, last_rd);
    tick();
    check("berr idle ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b10);

    // Silent backend: request held exactly 4 cycles, then ERROR.
    drive_addr(1'b1, 2'd2, 32'h24, 1'b0, 3'd2, 3'd0);
    tick();
    drive_addr(1'b1, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tmo req cycle%0d", k), {other_req_out, ahb_ready_out}, 2'b10);
      tick();
    end
    check("tmo err1 req", other_req_out, 0);
    check("tmo err1 ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b01);
    tick();
    check("tmo err2 ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b11);
    tick();
    check("tmo idle ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b10);

    // Reset in the middle of a data phase clears outputs without waiting for a clock.
    drive_addr(1'b1, 2'd2, 32'h28, 1'b0, 3'd2, 3'd0);
    tick();
    drive_addr(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 3'd0);
    check("mid req", other_req_out, 1);
    #2;
    ahb_rstn_in = 1'b0;
    #1;
    check("mid rst req", other_req_out, 0);
    check("mid rst ready/resp", {ahb_ready_out, ahb_resp_out}, 2'b10);
    check("mid rst rdata", ahb_rdata_out, 0);
    check("mid rst addr", other_addr_out, 0);
    check("mid rst strb", other_strb_out, 0);
    #2;
    ahb_rstn_in = 1'b1;
    tick();
    check("post rst req", other_req_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
